mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the byte-addressed single-port memory (`mem`: 15-bit byte address, 8-bit data, registered read path). Two requesters, port 0 (CPU) and port 1 (loader/debug), share the memory one transaction at a time. The block serialises their accesses and drives `mem`'s address, write and data inputs. It times the read latency and returns read data to the port that issued the read.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The arbitration mode is selected in mem_arb_pick by the MEM_ARB_RR_EN macro.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W   = 15;
  localparam int unsigned MEM_DATA_W   = 8;
  localparam int unsigned READ_LAT_DEF = 3;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned NUM_PORTS    = 2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // One port's request payload as seen by the issue registers.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the two request ports.
// MEM_ARB_RR_EN defined: round-robin against the last granted port; undefined: port 0 first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic                 last,
`endif
  output logic [NUM_PORTS-1:0] gnt_oh_c,
  output logic                 valid_c
);

  always_comb begin
    gnt_oh_c = '0;
    valid_c  = |req;
`ifdef MEM_ARB_RR_EN
    // On contention favour the port that did not win last time.
    if (req == 2'b11) begin
      gnt_oh_c = last ? 2'b01 : 2'b10;
    end else if (req[PORT_CPU]) begin
      gnt_oh_c = 2'b01;
    end else if (req[PORT_LDR]) begin
      gnt_oh_c = 2'b10;
    end
`else
    if (req[PORT_CPU]) begin
      gnt_oh_c = 2'b01;
    end else if (req[PORT_LDR]) begin
      gnt_oh_c = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for the single-port byte memory with a registered read path.
// Arbitration mode set by MEM_ARB_RR_EN (round-robin) or its absence (fixed port-0 priority).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [MEM_ADDR_W-1:0] p0_addr,
  input  logic [MEM_DATA_W-1:0] p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [MEM_ADDR_W-1:0] p1_addr,
  input  logic [MEM_DATA_W-1:0] p1_wdata,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [MEM_DATA_W-1:0] p0_rdata,
  output logic [MEM_DATA_W-1:0] p1_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_write,
  output logic [MEM_DATA_W-1:0] mem_data_in,
  input  logic [MEM_DATA_W-1:0] mem_data_out
);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  owner_q, owner_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  rvalid_q, rvalid_d;
  logic [MEM_DATA_W-1:0] rdata0_q, rdata0_d;
  logic [MEM_DATA_W-1:0] rdata1_q, rdata1_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_write_q, mem_write_d;
  logic [MEM_DATA_W-1:0] mem_data_in_q, mem_data_in_d;

  req_t                  p0_r, p1_r, win_r;
  logic [NUM_PORTS-1:0]  pick_gnt_c;
  logic                  pick_valid_c;

`ifdef MEM_ARB_RR_EN
  logic                  last_q, last_d;
`endif

  assign p0_r  = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
  assign p1_r  = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
  assign win_r = pick_gnt_c[PORT_LDR] ? p1_r : p0_r;

  mem_arb_pick u_pick (
    .req      ({p1_req, p0_req}),
`ifdef MEM_ARB_RR_EN
    .last     (last_q),
`endif
    .gnt_oh_c (pick_gnt_c),
    .valid_c  (pick_valid_c)
  );

  // Next-state and next-output logic; gnt, rvalid and mem_write are single-cycle by default.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    gnt_d         = '0;
    rvalid_d      = '0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_addr_d    = mem_addr_q;
    mem_write_d   = 1'b0;
    mem_data_in_d = mem_data_in_q;
`ifdef MEM_ARB_RR_EN
    last_d        = last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          owner_d       = pick_gnt_c[PORT_LDR];
          gnt_d         = pick_gnt_c;
          mem_addr_d    = win_r.addr;
          mem_write_d   = win_r.we;
          mem_data_in_d = win_r.wdata;
          state_d       = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
          last_d        = pick_gnt_c[PORT_LDR];
`endif
        end
      end
      ST_ISSUE: begin
        if (mem_write_q) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The memory output is valid in the cycle the counter reaches zero.
        if (cnt_q == '0) begin
          if (owner_q == PORT_LDR) begin
            rdata1_d = mem_data_out;
          end else begin
            rdata0_d = mem_data_out;
          end
          rvalid_d[owner_q] = 1'b1;
          state_d           = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      owner_q       <= PORT_CPU;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_addr_q    <= '0;
      mem_write_q   <= 1'b0;
      mem_data_in_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q        <= PORT_LDR;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      mem_addr_q    <= mem_addr_d;
      mem_write_q   <= mem_write_d;
      mem_data_in_q <= mem_data_in_d;
`ifdef MEM_ARB_RR_EN
      last_q        <= last_d;
`endif
    end
  end

  assign p0_gnt      = gnt_q[PORT_CPU];
  assign p1_gnt      = gnt_q[PORT_LDR];
  assign p0_rvalid   = rvalid_q[PORT_CPU];
  assign p1_rvalid   = rvalid_q[PORT_LDR];
  assign p0_rdata    = rdata0_q;
  assign p1_rdata    = rdata1_q;
  assign mem_addr    = mem_addr_q;
  assign mem_write   = mem_write_q;
  assign mem_data_in = mem_data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, vector table, corner sequences, random traffic.
module tb_mem_arbiter;

  localparam int RL = 3;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [14:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [14:0] mem_addr;
  logic        mem_write;
  logic [7:0]  mem_data_in, mem_data_out;

  int checks = 0;
  int passed = 0;
  bit mon_en = 0;
  bit last_port = 0;

  logic [7:0] ref_mem [int];

  mem_arbiter #(.READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: registered read followed by RL-1 further delay stages.
  logic [7:0] mem_arr [0:32767];
  logic [7:0] pipe [RL];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr] <= mem_data_in;
    pipe[0] <= mem_arr[mem_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_data_out = pipe[RL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Mutual exclusion of grants/rvalids and mem_write only during a grant cycle.
  always @(negedge clk) begin
    if (mon_en)
      check("exclusive", 32'({p0_gnt & p1_gnt, p0_rvalid & p1_rvalid,
                              mem_write & ~(p0_gnt | p1_gnt)}), 32'd0);
  end

  task automatic do_txn(input bit port, input bit we, input logic [14:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp, input string nm);
    int n;
    bit got;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++;
      got = port ? p1_gnt : p0_gnt;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    check({nm, "_gnt_lat"}, 32'(n), 32'd1);
    if (!got) return;
    last_port = port;
    check({nm, "_addr"}, 32'(mem_addr), 32'(addr));
    check({nm, "_we"}, 32'(mem_write), 32'(we));
    if (we) begin
      check({nm, "_wdata"}, 32'(mem_data_in), 32'(wdata));
      ref_mem[int'(addr)] = wdata;
      @(posedge clk); #1;
      check({nm, "_we_low"}, 32'(mem_write), 32'd0);
    end else begin
      n = 0; got = 0;
      while (!got && n < RL + 10) begin
        @(posedge clk); #1; n++;
        got = port ? p1_rvalid : p0_rvalid;
      end
      check({nm, "_rd_lat"}, 32'(n), 32'(RL + 1));
      check({nm, "_rdata"}, 32'(port ? p1_rdata : p0_rdata), 32'(exp));
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    bit         port;
    bit         we;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int gport [$];
    int gcyc [$];
    int cyc, nrv, owner, n, exp_p;
    bit got;
    logic [14:0] pool [8];

    vecs[0]  = '{1'b0, 1'b1, 15'h0003, 8'hA5, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 15'h0003, 8'h00, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 15'h0010, 8'h11, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 15'h0011, 8'h22, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 15'h0010, 8'h00, 8'h11};
    vecs[5]  = '{1'b1, 1'b0, 15'h0011, 8'h00, 8'h22};
    vecs[6]  = '{1'b1, 1'b0, 15'h0003, 8'h00, 8'hA5};
    vecs[7]  = '{1'b1, 1'b1, 15'h7FFF, 8'hFF, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 8'hFF};
    vecs[9]  = '{1'b0, 1'b1, 15'h0000, 8'h3C, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 15'h0000, 8'h00, 8'h3C};
    vecs[11] = '{1'b0, 1'b0, 15'h0010, 8'h00, 8'h11};

    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 15'h0100; p0_wdata = 8'h5A;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;

    // Reset held two cycles with a pending request.
    @(posedge clk); #1;
    check("rst_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    check("rst_we", 32'(mem_write), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_din", 32'(mem_data_in), 32'd0);
    check("rst_rvalid", 32'({p0_rvalid, p1_rvalid}), 32'd0);
    check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);
    @(posedge clk); #1;
    check("rst2_gnt", 32'({p0_gnt, p1_gnt}), 32'd0);
    check("rst2_we", 32'(mem_write), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rel_gnt", 32'({p1_gnt, p0_gnt}), 32'd1);
    check("rel_addr", 32'(mem_addr), 32'h0100);
    check("rel_we", 32'(mem_write), 32'd1);
    p0_req = 1'b0;
    ref_mem[32'h0100] = 8'h5A;
    last_port = 1'b0;
    @(posedge clk); #1;
    check("rel_we_low", 32'(mem_write), 32'd0);

    for (int i = 0; i < 12; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp,
             $sformatf("vec%0d", i));

    // Contention: both ports read continuously.
    p0_we = 1'b0; p0_addr = 15'h0010; p1_we = 1'b0; p1_addr = 15'h0011;
    p0_req = 1'b1; p1_req = 1'b1;
    cyc = 0; nrv = 0; owner = -1;
    for (int i = 0; i < 8 * (RL + 3) && gport.size() < 6; i++) begin
      @(posedge clk); #1; cyc++;
      if (p0_gnt || p1_gnt) begin
        owner = p1_gnt ? 1 : 0;
        gport.push_back(owner);
        gcyc.push_back(cyc);
`ifndef MEM_ARB_RR_EN
        if (gport.size() == 4) p0_req = 1'b0;
`endif
      end
      if (p0_rvalid || p1_rvalid) begin
        nrv++;
        check("cont_rv_owner", 32'(p1_rvalid), 32'(owner));
        check("cont_rdata", 32'(p1_rvalid ? p1_rdata : p0_rdata), owner == 1 ? 32'h22 : 32'h11);
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    for (int i = 0; i < RL + 3; i++) begin
      @(posedge clk); #1;
      if (p0_rvalid || p1_rvalid) begin
        nrv++;
        check("cont_rv_owner", 32'(p1_rvalid), 32'(owner));
        check("cont_rdata", 32'(p1_rvalid ? p1_rdata : p0_rdata), owner == 1 ? 32'h22 : 32'h11);
      end
    end
    check("cont_ngnt", 32'(gport.size()), 32'd6);
    check("cont_nrv", 32'(nrv), 32'd6);
    for (int k = 0; k < gport.size(); k++) begin
`ifdef MEM_ARB_RR_EN
      exp_p = (int'(!last_port) + k) % 2;
`else
      exp_p = (k < 4) ? 0 : 1;
`endif
      check($sformatf("cont_gnt%0d", k), 32'(gport[k]), 32'(exp_p));
      if (k > 0) check($sformatf("cont_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'(RL + 3));
    end
    if (gport.size() > 0) last_port = gport[gport.size()-1] == 1;

    // Reset while a read is waiting on the memory.
    p0_we = 1'b0; p0_addr = 15'h0003; p0_req = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(posedge clk); #1; n++; got = p0_gnt;
    end
    p0_req = 1'b0;
    check("mid_gnt_lat", 32'(n), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_out", 32'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write}), 32'd0);
    check("mid_rst_rdata", 32'(p0_rdata), 32'd0);
    rst_n = 1'b1;
    nrv = 0;
    for (int i = 0; i < RL + 4; i++) begin
      @(posedge clk); #1;
      if (p0_rvalid || p1_rvalid) nrv++;
    end
    check("mid_no_rvalid", 32'(nrv), 32'd0);
    do_txn(1'b0, 1'b0, 15'h0003, 8'h00, 8'hA5, "post_rst");

    // Randomised single-port traffic against the reference byte map.
    for (int i = 0; i < 8; i++) pool[i] = 15'($urandom);
    for (int i = 0; i < 120; i++) begin
      logic [14:0] a;
      bit pt, w;
      logic [7:0] d;
      a  = pool[$urandom_range(0, 7)];
      pt = 1'($urandom_range(0, 1));
      w  = !ref_mem.exists(int'(a)) || ($urandom_range(0, 1) == 1);
      d  = 8'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(posedge clk); #1;
      end
      do_txn(pt, w, a, d, w ? 8'h00 : ref_mem[int'(a)], $sformatf("rnd%0d", i));
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
